// File: rtl/seq_divider16_if.sv
// -----------------------------------------------------------------------------
// seq_divider16_if
//   Handshake bundle for the sequential restoring divider. Signal names keep
//   the divider's point of view (_i into the divider, _o out of it).
//
//   Operand side : valid_i, ready_o, dividend_i, divisor_i
//   Result side  : valid_o, ready_i, quotient_o, remainder_o, div_by_zero_o
//
//   Modports
//     master : the requester that issues operands and consumes results
//     slave  : the divider itself
// -----------------------------------------------------------------------------
interface seq_divider16_if #(
    parameter int unsigned WIDTH = 16
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_by_zero_o;

    modport master (
        output valid_i,
        output dividend_i,
        output divisor_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  quotient_o,
        input  remainder_o,
        input  div_by_zero_o
    );

    modport slave (
        input  valid_i,
        input  dividend_i,
        input  divisor_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output quotient_o,
        output remainder_o,
        output div_by_zero_o
    );
endinterface

// File: rtl/seq_divider16.sv
// -----------------------------------------------------------------------------
// seq_divider16
//   Sequential unsigned restoring divider, one quotient bit per clock.
//   Operands are taken over a valid/ready handshake; quotient and remainder
//   are returned over a second valid/ready handshake. valid_o rises WIDTH
//   clocks after the accepting edge; there is no overlap between operations.
//
//   Ports
//     clk_i    : clock, rising edge
//     rst_n_i  : asynchronous active-low reset
//     bus      : seq_divider16_if.slave
//                valid_i/ready_o/dividend_i/divisor_i  operand handshake
//                valid_o/ready_i/quotient_o/remainder_o/div_by_zero_o
//                                                      result handshake
//
//   Build option
//     SEQ_DIVIDER16_DIVZERO_EN : when defined, a zero divisor bypasses the
//     iterative path, completes on the accepting edge, and raises
//     div_by_zero_o. When undefined, a zero divisor runs the normal WIDTH
//     steps (quotient all ones, remainder = dividend) and div_by_zero_o is 0.
// -----------------------------------------------------------------------------
module seq_divider16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    seq_divider16_if.slave       bus
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e           state_q, state_d;

    logic [CntW-1:0]  cnt_q, cnt_d;
    // Partial remainder is always < divisor between steps (or equals the
    // dividend prefix for a zero divisor), so WIDTH bits hold it; the
    // shifted value used for the compare is WIDTH+1 bits wide.
    logic [WIDTH-1:0] prem_q, prem_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   prem_shift;
    logic [WIDTH:0]   prem_sub;
    logic             q_bit;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] quo_next;

    assign accept    = bus.valid_i && (state_q == StIdle);
    assign last_step = (cnt_q == CntW'(WIDTH - 1));

    // One restoring step.
    always_comb begin
        prem_shift = {prem_q, dvd_q[WIDTH-1]};
        prem_sub   = prem_shift - {1'b0, dvs_q};
        q_bit      = (prem_shift >= {1'b0, dvs_q});
        prem_next  = q_bit ? prem_sub[WIDTH-1:0] : prem_shift[WIDTH-1:0];
        quo_next   = {dvd_q[WIDTH-2:0], q_bit};
    end

`ifdef SEQ_DIVIDER16_DIVZERO_EN
    logic dbz_q, dbz_d;
    logic div_zero;

    assign div_zero = (bus.divisor_i == '0);
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef SEQ_DIVIDER16_DIVZERO_EN
                    state_d = div_zero ? StDone : StBusy;
`else
                    state_d = StBusy;
`endif
                end
            end
            StBusy: begin
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus.ready_o = (state_q == StIdle);
        bus.valid_o = (state_q == StDone);
    end

    // -------------------------------------------------------------------------
    // Datapath next state
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q;
        prem_d = prem_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
`ifdef SEQ_DIVIDER16_DIVZERO_EN
        dbz_d  = dbz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    dvd_d  = bus.dividend_i;
                    dvs_d  = bus.divisor_i;
                    prem_d = '0;
                    cnt_d  = '0;
`ifdef SEQ_DIVIDER16_DIVZERO_EN
                    dbz_d  = div_zero;
                    if (div_zero) begin
                        // Same values the iterative path would have produced.
                        quo_d = '1;
                        rem_d = bus.dividend_i;
                    end
`endif
                end
            end
            StBusy: begin
                prem_d = prem_next;
                dvd_d  = quo_next;
                cnt_d  = cnt_q + CntW'(1);
                if (last_step) begin
                    quo_d = quo_next;
                    rem_d = prem_next;
                end
            end
            StDone: begin
                // Results held until taken, and kept afterwards.
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            prem_q <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            prem_q <= prem_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
        end
    end

`ifdef SEQ_DIVIDER16_DIVZERO_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end

    assign bus.div_by_zero_o = dbz_q;
`else
    assign bus.div_by_zero_o = 1'b0;
`endif

    assign bus.quotient_o  = quo_q;
    assign bus.remainder_o = rem_q;

endmodule

// File: tb/tb_seq_divider16.sv
// -----------------------------------------------------------------------------
// tb_seq_divider16
//   Scoreboard bench for seq_divider16. The driver pushes the hand-computed
//   result of every accepted operation; a monitor compares each presented
//   result (every cycle valid_o is high) and pops it on the result handshake.
// -----------------------------------------------------------------------------
module tb_seq_divider16;

    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;

    seq_divider16_if #(.WIDTH(W)) dif ();

    seq_divider16 #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;  // rising edges after the accepting edge until valid_o
        int           acc;  // index of the accepting rising edge
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   vo_prev = 1'b0;

`ifdef SEQ_DIVIDER16_DIVZERO_EN
    // valid_o is already high in the cycle right after the accepting edge.
    localparam int  DzLat  = 0;
    localparam bit  DzFlag = 1'b1;
`else
    localparam int  DzLat  = 16;
    localparam bit  DzFlag = 1'b0;
`endif

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && dif.valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got q=0x%0h r=0x%0h expected none",
                         dif.quotient_o, dif.remainder_o);
            end else begin
                if (!vo_prev) chk("latency", cyc - sb[0].acc, sb[0].lat);
                chk("quotient", dif.quotient_o, sb[0].q);
                chk("remainder", dif.remainder_o, sb[0].r);
                chk("div_by_zero", dif.div_by_zero_o, sb[0].dbz);
                chk("ready_o_while_done", dif.ready_o, 1'b0);
                if (dif.ready_i) void'(sb.pop_front());
            end
        end
        vo_prev = rst_n && dif.valid_o;
    end

    // Present operands until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] qe, input logic [W-1:0] re,
                        input logic dz, input int lat, input bit hold);
        int n = 0;
        exp_t e;
        dif.valid_i    = 1'b1;
        dif.dividend_i = a;
        dif.divisor_i  = b;
        @(negedge clk);
        while (!dif.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!dif.ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready_o=0 expected 1");
        end else begin
            e.q = qe; e.r = re; e.dbz = dz; e.lat = lat; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        if (!hold) dif.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        dif.valid_i    = 1'b0;
        dif.ready_i    = 1'b1;
        dif.dividend_i = '0;
        dif.divisor_i  = '0;
        #12;
        chk("rst_ready_o", dif.ready_o, 1'b1);
        chk("rst_valid_o", dif.valid_o, 1'b0);
        chk("rst_quotient", dif.quotient_o, 16'h0);
        chk("rst_remainder", dif.remainder_o, 16'h0);
        chk("rst_div_by_zero", dif.div_by_zero_o, 1'b0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        send(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, 1'b0);
        drain();
        chk("ready_o_after_take", dif.ready_o, 1'b1);
        chk("valid_o_after_take", dif.valid_o, 1'b0);
        send(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16, 1'b0);
        drain();
        send(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16, 1'b0);
        drain();
        send(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, DzFlag, DzLat, 1'b0);
        drain();
        send(16'd5, 16'd10, 16'd0, 16'd5, 1'b0, 16, 1'b0);
        drain();

        // Backpressure: result held 3 cycles, stray valid_i ignored
        dif.ready_i = 1'b0;
        send(16'h8000, 16'h0003, 16'd10922, 16'd2, 1'b0, 16, 1'b0);
        begin
            int n = 0;
            while (!dif.valid_o && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("bp_valid_o_rose", dif.valid_o, 1'b1);
        @(posedge clk); #1;
        dif.valid_i    = 1'b1;
        dif.dividend_i = 16'h0042;
        dif.divisor_i  = 16'h0002;
        @(posedge clk); #1;
        dif.valid_i = 1'b0;
        chk("bp_ready_o_low", dif.ready_o, 1'b0);
        @(posedge clk); #1;
        dif.ready_i = 1'b1;
        drain();
        repeat (20) @(posedge clk);
        #1;
        chk("bp_no_stray_result", dif.valid_o, 1'b0);

        // Asynchronous reset in the middle of BUSY
        send(16'hABCD, 16'h0003, 16'h0000, 16'h0000, 1'b0, 16, 1'b0);
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_ready_o", dif.ready_o, 1'b1);
        chk("abort_valid_o", dif.valid_o, 1'b0);
        chk("abort_quotient", dif.quotient_o, 16'h0);
        chk("abort_remainder", dif.remainder_o, 16'h0);
        chk("abort_div_by_zero", dif.div_by_zero_o, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 16, 1'b0);
        drain();

        // Back-to-back with valid_i held high
        send(16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 16, 1'b1);
        send(16'd7, 16'd7, 16'd1, 16'd0, 1'b0, 16, 1'b0);
        drain();
        chk("final_idle", dif.ready_o, 1'b1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
